// File: rtl/picorv32_alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: RV32I opcode/funct fields, ALU op
// select and the instruction decoder used by the issue logic.
package picorv32_alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {
    OP2_RS2,
    OP2_IMM,
    OP2_SHAMT
  } op2_sel_e;

  typedef struct packed {
    alu_op_e  op;
    logic     uses_rs2;
    op2_sel_e op2_sel;
  } dec_t;

  // ALU_NONE in the result marks an unsupported encoding.
  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic en_imm);
    dec_t d;
    d.op       = ALU_NONE;
    d.uses_rs2 = 1'b0;
    d.op2_sel  = OP2_RS2;
    if (opc == OPC_OP) begin
      d.uses_rs2 = 1'b1;
      case (f3)
        F3_ADD: if (f7 == F7_BASE) d.op = ALU_ADD; else if (f7 == F7_ALT) d.op = ALU_SUB;
        F3_SR:  if (f7 == F7_BASE) d.op = ALU_SRL; else if (f7 == F7_ALT) d.op = ALU_SRA;
        F3_SLL: if (f7 == F7_BASE) d.op = ALU_SLL;
        F3_XOR: if (f7 == F7_BASE) d.op = ALU_XOR;
        F3_OR:  if (f7 == F7_BASE) d.op = ALU_OR;
        F3_AND: if (f7 == F7_BASE) d.op = ALU_AND;
        default: d.op = ALU_NONE;
      endcase
    end else if (opc == OPC_OP_IMM && en_imm) begin
      d.op2_sel = OP2_IMM;
      case (f3)
        F3_ADD: d.op = ALU_ADD;
        F3_XOR: d.op = ALU_XOR;
        F3_OR:  d.op = ALU_OR;
        F3_AND: d.op = ALU_AND;
        F3_SLL: begin
          d.op2_sel = OP2_SHAMT;
          if (f7 == F7_BASE) d.op = ALU_SLL;
        end
        F3_SR: begin
          d.op2_sel = OP2_SHAMT;
          if (f7 == F7_BASE) d.op = ALU_SRL; else if (f7 == F7_ALT) d.op = ALU_SRA;
        end
        default: d.op = ALU_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/picorv32_alu_issue_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 reads as zero. Not reset.
module picorv32_alu_regfile
  #(parameter int unsigned NREGS = 32)
  (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
  );

  localparam int unsigned AW = $clog2(NREGS);

  logic [31:0] mem [NREGS];
  logic        w_in_range, r1_in_range, r2_in_range;

  // Only 16- or 32-entry files are built, so bit 4 decides the range.
  always_comb begin
    w_in_range  = (NREGS > 16) || !waddr[4];
    r1_in_range = (NREGS > 16) || !raddr1[4];
    r2_in_range = (NREGS > 16) || !raddr2[4];
    rdata1 = (raddr1 != '0 && r1_in_range) ? mem[raddr1[AW-1:0]] : '0;
    rdata2 = (raddr2 != '0 && r2_in_range) ? mem[raddr2[AW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (we && waddr != '0 && w_in_range)
      mem[waddr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/picorv32_alu_issue.sv
// Decode/issue stage ahead of the picorv32 ALU: decodes OP/OP-IMM words,
// reads operands with writeback bypass, tracks pending destinations.
module picorv32_alu_issue
  import picorv32_alu_issue_pkg::*;
  #(
    parameter bit ENABLE_REGS_16_31 = 1'b1,
    parameter bit ENABLE_IMM        = 1'b1
  )
  (
    input  logic        clk,
    input  logic        resetn,
    input  logic        insn_valid,
    output logic        insn_ready,
    input  logic [31:0] insn_data,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [31:0] reg_op1,
    output logic [31:0] reg_op2,
    output logic [4:0]  alu_rd,
    output logic        instr_add,
    output logic        instr_sub,
    output logic        instr_and,
    output logic        instr_or,
    output logic        instr_xor,
    output logic        instr_sll,
    output logic        instr_srl,
    output logic        instr_sra,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        insn_illegal
  );

  logic [4:0]  rs1, rs2, rd;
  dec_t        dec;
  logic        legal, hazard, accept, issue, wb_we;
  logic [31:0] rf_rd1, rf_rd2, op1, op2;

  logic        alu_valid_q, alu_valid_d;
  alu_op_e     op_q, op_d;
  logic [31:0] reg_op1_q, reg_op1_d, reg_op2_q, reg_op2_d;
  logic [4:0]  alu_rd_q, alu_rd_d;
  logic        insn_illegal_q, insn_illegal_d;
  logic [31:0] pending_q, pending_d;

  assign rs1 = insn_data[19:15];
  assign rs2 = insn_data[24:20];
  assign rd  = insn_data[11:7];

  picorv32_alu_regfile #(.NREGS(ENABLE_REGS_16_31 ? 32 : 16)) u_regfile (
    .clk    (clk),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  always_comb begin
    dec   = decode(insn_data[6:0], insn_data[14:12], insn_data[31:25], ENABLE_IMM);
    legal = (dec.op != ALU_NONE) &&
            (ENABLE_REGS_16_31 || !(rd[4] || rs1[4] || (dec.uses_rs2 && rs2[4])));

    wb_we = wb_valid && wb_rd != '0 && (ENABLE_REGS_16_31 || !wb_rd[4]);

    // A writeback landing this cycle resolves the hazard it would clear.
    hazard = (pending_q[rs1] && !(wb_valid && wb_rd == rs1)) ||
             (dec.uses_rs2 && pending_q[rs2] && !(wb_valid && wb_rd == rs2));

    insn_ready = (!alu_valid_q || alu_ready) && !hazard;
    accept     = insn_valid && insn_ready;
    issue      = accept && legal;

    op1 = (wb_valid && wb_rd == rs1 && rs1 != '0) ? wb_data : rf_rd1;
    case (dec.op2_sel)
      OP2_IMM:   op2 = {{20{insn_data[31]}}, insn_data[31:20]};
      OP2_SHAMT: op2 = {27'b0, insn_data[24:20]};
      default:   op2 = (wb_valid && wb_rd == rs2 && rs2 != '0) ? wb_data : rf_rd2;
    endcase
  end

  always_comb begin
    alu_valid_d = alu_valid_q;
    op_d        = op_q;
    reg_op1_d   = reg_op1_q;
    reg_op2_d   = reg_op2_q;
    alu_rd_d    = alu_rd_q;
    pending_d   = pending_q;

    if (alu_valid_q && alu_ready) begin
      alu_valid_d = 1'b0;
      op_d        = ALU_NONE;
    end
    if (issue) begin
      alu_valid_d = 1'b1;
      op_d        = dec.op;
      reg_op1_d   = op1;
      reg_op2_d   = op2;
      alu_rd_d    = rd;
    end

    insn_illegal_d = accept && !legal;

    // Set after clear so a same-cycle issue to the written register stays pending.
    if (wb_we)
      pending_d[wb_rd] = 1'b0;
    if (issue && rd != '0)
      pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_valid_q    <= 1'b0;
      op_q           <= ALU_NONE;
      reg_op1_q      <= '0;
      reg_op2_q      <= '0;
      alu_rd_q       <= '0;
      insn_illegal_q <= 1'b0;
      pending_q      <= '0;
    end else begin
      alu_valid_q    <= alu_valid_d;
      op_q           <= op_d;
      reg_op1_q      <= reg_op1_d;
      reg_op2_q      <= reg_op2_d;
      alu_rd_q       <= alu_rd_d;
      insn_illegal_q <= insn_illegal_d;
      pending_q      <= pending_d;
    end
  end

  assign alu_valid    = alu_valid_q;
  assign reg_op1      = reg_op1_q;
  assign reg_op2      = reg_op2_q;
  assign alu_rd       = alu_rd_q;
  assign insn_illegal = insn_illegal_q;
  assign instr_add    = (op_q == ALU_ADD);
  assign instr_sub    = (op_q == ALU_SUB);
  assign instr_and    = (op_q == ALU_AND);
  assign instr_or     = (op_q == ALU_OR);
  assign instr_xor    = (op_q == ALU_XOR);
  assign instr_sll    = (op_q == ALU_SLL);
  assign instr_srl    = (op_q == ALU_SRL);
  assign instr_sra    = (op_q == ALU_SRA);

endmodule

// File: tb/tb_picorv32_alu_issue.sv
// Directed bench for picorv32_alu_issue: decode vector table plus reset,
// RAW stall/bypass, backpressure and illegal-pulse sequences.
module tb_picorv32_alu_issue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] reg_op1, reg_op2;
  logic [4:0]  alu_rd;
  logic        instr_add, instr_sub, instr_and, instr_or;
  logic        instr_xor, instr_sll, instr_srl, instr_sra;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        insn_illegal;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0] ADD = 8'h01, SUB = 8'h02, AND = 8'h04, OR = 8'h08;
  localparam logic [7:0] XOR = 8'h10, SLL = 8'h20, SRL = 8'h40, SRA = 8'h80;

  typedef struct {
    logic [31:0] insn;
    logic        illegal;
    logic [7:0]  ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vt[$];

  picorv32_alu_issue #(.ENABLE_REGS_16_31(1'b1), .ENABLE_IMM(1'b1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn_data    (insn_data),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .reg_op1      (reg_op1),
    .reg_op2      (reg_op2),
    .alu_rd       (alu_rd),
    .instr_add    (instr_add),
    .instr_sub    (instr_sub),
    .instr_and    (instr_and),
    .instr_or     (instr_or),
    .instr_xor    (instr_xor),
    .instr_sll    (instr_sll),
    .instr_srl    (instr_srl),
    .instr_sra    (instr_sra),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .insn_illegal (insn_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'b0010011};
  endfunction

  function automatic logic [7:0] ops_now();
    return {instr_sra, instr_srl, instr_sll, instr_xor, instr_or, instr_and, instr_sub, instr_add};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = d;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  // Present a word, wait (bounded) for acceptance, return at the negedge after it.
  task automatic send(input logic [31:0] w);
    bit ok = 1'b0;
    insn_data  = w;
    insn_valid = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (insn_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (ok) @(negedge clk);
    insn_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept for insn 0x%08h", w);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    insn_valid = 1'b1;
    insn_data  = 32'h002081B3;
    alu_ready  = 1'b1;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;

    // Reset held two cycles with a valid word on the input.
    repeat (2) @(negedge clk);
    chk("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
    chk("rst_instr", {24'b0, ops_now()}, 32'd0);
    chk("rst_op1", reg_op1, 32'd0);
    chk("rst_op2", reg_op2, 32'd0);
    chk("rst_rd", {27'b0, alu_rd}, 32'd0);
    chk("rst_illegal", {31'b0, insn_illegal}, 32'd0);
    insn_valid = 1'b0;
    resetn     = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, insn_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, alu_valid}, 32'd0);

    wb(5'd1, 32'd10);
    wb(5'd2, 32'd5);
    wb(5'd5, 32'hFFFF_FFF0);
    wb(5'd7, 32'h8000_0001);

    vt.push_back('{32'h002081B3,             1'b0, ADD, 32'd10,          32'd5,           5'd3});
    vt.push_back('{32'h402081B3,             1'b0, SUB, 32'd10,          32'd5,           5'd3});
    vt.push_back('{enc_r(7'h00, 7, 5, 7, 21), 1'b0, AND, 32'hFFFF_FFF0,   32'h8000_0001,   5'd21});
    vt.push_back('{enc_r(7'h00, 2, 1, 6, 21), 1'b0, OR,  32'd10,          32'd5,           5'd21});
    vt.push_back('{enc_r(7'h00, 2, 1, 4, 21), 1'b0, XOR, 32'd10,          32'd5,           5'd21});
    vt.push_back('{enc_r(7'h00, 2, 1, 1, 22), 1'b0, SLL, 32'd10,          32'd5,           5'd22});
    vt.push_back('{enc_r(7'h00, 2, 5, 5, 22), 1'b0, SRL, 32'hFFFF_FFF0,   32'd5,           5'd22});
    vt.push_back('{enc_r(7'h20, 2, 5, 5, 22), 1'b0, SRA, 32'hFFFF_FFF0,   32'd5,           5'd22});
    vt.push_back('{enc_i(12'hFFF, 1, 0, 23),  1'b0, ADD, 32'd10,          32'hFFFF_FFFF,   5'd23});
    vt.push_back('{enc_i(12'h7FF, 2, 4, 23),  1'b0, XOR, 32'd5,           32'h0000_07FF,   5'd23});
    vt.push_back('{enc_i(12'h800, 5, 6, 23),  1'b0, OR,  32'hFFFF_FFF0,   32'hFFFF_F800,   5'd23});
    vt.push_back('{enc_i(12'h0F0, 7, 7, 23),  1'b0, AND, 32'h8000_0001,   32'h0000_00F0,   5'd23});
    vt.push_back('{enc_i(12'h01F, 1, 1, 24),  1'b0, SLL, 32'd10,          32'd31,          5'd24});
    vt.push_back('{enc_i(12'h004, 5, 5, 24),  1'b0, SRL, 32'hFFFF_FFF0,   32'd4,           5'd24});
    vt.push_back('{enc_i(12'h402, 5, 5, 4),   1'b0, SRA, 32'hFFFF_FFF0,   32'd2,           5'd4});
    vt.push_back('{enc_r(7'h00, 2, 1, 0, 0),  1'b0, ADD, 32'd10,          32'd5,           5'd0});
    vt.push_back('{enc_r(7'h00, 2, 0, 0, 24), 1'b0, ADD, 32'd0,           32'd5,           5'd24});
    vt.push_back('{32'h0020A1B3,             1'b1, 8'h00, 32'd0, 32'd0, 5'd0});
    vt.push_back('{enc_r(7'h00, 2, 1, 3, 3),  1'b1, 8'h00, 32'd0, 32'd0, 5'd0});
    vt.push_back('{32'h00000003,             1'b1, 8'h00, 32'd0, 32'd0, 5'd0});
    vt.push_back('{enc_r(7'h20, 2, 1, 1, 3),  1'b1, 8'h00, 32'd0, 32'd0, 5'd0});
    vt.push_back('{enc_r(7'h01, 2, 1, 0, 3),  1'b1, 8'h00, 32'd0, 32'd0, 5'd0});
    vt.push_back('{enc_i(12'h401, 1, 1, 3),   1'b1, 8'h00, 32'd0, 32'd0, 5'd0});
    vt.push_back('{enc_i(12'h020, 1, 1, 3),   1'b1, 8'h00, 32'd0, 32'd0, 5'd0});

    foreach (vt[i]) begin
      send(vt[i].insn);
      chk($sformatf("v%0d_illegal", i), {31'b0, insn_illegal}, {31'b0, vt[i].illegal});
      chk($sformatf("v%0d_valid", i), {31'b0, alu_valid}, {31'b0, !vt[i].illegal});
      chk($sformatf("v%0d_instr", i), {24'b0, ops_now()}, {24'b0, vt[i].ops});
      if (!vt[i].illegal) begin
        chk($sformatf("v%0d_op1", i), reg_op1, vt[i].op1);
        chk($sformatf("v%0d_op2", i), reg_op2, vt[i].op2);
        chk($sformatf("v%0d_rd", i), {27'b0, alu_rd}, {27'b0, vt[i].rd});
      end
    end

    // Illegal word: pulse lasts exactly one cycle.
    send(32'h0020A1B3);
    chk("ill_pulse_hi", {31'b0, insn_illegal}, 32'd1);
    @(negedge clk);
    chk("ill_pulse_lo", {31'b0, insn_illegal}, 32'd0);
    chk("ill_no_issue", {31'b0, alu_valid}, 32'd0);

    // RAW on x3: stall until writeback, then accept in the same cycle with bypass.
    send(32'h002081B3);
    insn_data  = enc_r(7'h00, 1, 3, 4, 6);
    insn_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("raw_stall%0d", c), {31'b0, insn_ready}, 32'd0);
      @(negedge clk);
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'd15;
    #1;
    chk("raw_ready_on_wb", {31'b0, insn_ready}, 32'd1);
    @(negedge clk);
    wb_valid   = 1'b0;
    insn_valid = 1'b0;
    chk("raw_valid", {31'b0, alu_valid}, 32'd1);
    chk("raw_instr", {24'b0, ops_now()}, {24'b0, XOR});
    chk("raw_op1_bypass", reg_op1, 32'd15);
    chk("raw_op2", reg_op2, 32'd10);
    chk("raw_rd", {27'b0, alu_rd}, 32'd6);

    // Backpressure: slot frozen for 4 cycles, then the waiting word issues.
    send(enc_r(7'h00, 2, 1, 0, 25));
    alu_ready  = 1'b0;
    insn_data  = enc_r(7'h00, 2, 1, 6, 26);
    insn_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), {31'b0, insn_ready}, 32'd0);
      chk($sformatf("bp_valid%0d", c), {31'b0, alu_valid}, 32'd1);
      chk($sformatf("bp_instr%0d", c), {24'b0, ops_now()}, {24'b0, ADD});
      chk($sformatf("bp_op1_%0d", c), reg_op1, 32'd10);
      chk($sformatf("bp_rd%0d", c), {27'b0, alu_rd}, 32'd25);
      @(negedge clk);
    end
    alu_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, insn_ready}, 32'd1);
    @(negedge clk);
    insn_valid = 1'b0;
    chk("bp_next_instr", {24'b0, ops_now()}, {24'b0, OR});
    chk("bp_next_rd", {27'b0, alu_rd}, 32'd26);

    // Writes to x0 are dropped; x0 still reads zero.
    wb(5'd0, 32'h0000_1234);
    send(enc_r(7'h00, 0, 0, 0, 27));
    chk("x0_op1", reg_op1, 32'd0);
    chk("x0_op2", reg_op2, 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
